// File: rtl/uart_rx_fifo_mmio.sv
// uart_rx_fifo_mmio
//   Receives frames from the UART receiver, checks their parity and buffers
//   them in a DEPTH-entry FIFO. The core reads the FIFO through memory-mapped
//   registers. A level interrupt is raised while data is waiting.
//
// Ports
//   clk       system clock
//   rst       synchronous active-high reset
//   rx_sr     receiver frame register: [8] parity bit, [7:0] data byte
//   rx_ready  receiver capture strobe, high for one or more cycles per frame
//   sel       peripheral selected by the bus decoder
//   we        1 = write, 0 = read (qualified by sel)
//   addr      byte offset: 0x0 DATA, 0x4 STATUS, 0x8 CTRL
//   wdata     write data
//   rdata     read data, combinational from addr and the current state
//   irq       interrupt, irq_en & ~empty
module uart_rx_fifo_mmio #(
    parameter int DEPTH      = 16,
    parameter int PTR_W      = 4,
    parameter int PARITY_ODD = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [8:0]  rx_sr,
    input  logic        rx_ready,
    input  logic        sel,
    input  logic        we,
    input  logic [3:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    logic [8:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic             rdy_q_reg;
    logic             rdy_q2_reg;
    logic             overrun_reg;
    logic             perr_sticky_reg;
    logic             irq_en_reg;

    logic             empty;
    logic             full;
    logic             push_strobe;
    logic             perr;
    logic             ctrl_wr;
    logic             flush;
    logic             pop_req;
    logic             push_ok;
    logic             pop_ok;
    logic [PTR_W-1:0] wr_idx;
    logic [8:0]       head;
    logic [4:0]       count5;
    logic             unused_wdata;

    assign empty       = (count_reg == '0);
    assign full        = (count_reg == (PTR_W+1)'(DEPTH));
    // Rising edge of ready, one cycle late: rx_sr has settled by then.
    assign push_strobe = rdy_q_reg & ~rdy_q2_reg;
    assign perr        = (^rx_sr) ^ (PARITY_ODD != 0);
    assign ctrl_wr     = sel & we & (addr == 4'h8);
    assign flush       = ctrl_wr & wdata[3];
    assign pop_req     = sel & ~we & (addr == 4'h0);
    // A flush empties the FIFO first, so a push arriving with it is kept
    // and lands in entry 0; a pop in the same cycle is discarded.
    assign push_ok     = push_strobe & (~full | flush);
    assign pop_ok      = pop_req & ~empty & ~flush;
    assign wr_idx      = flush ? '0 : wr_ptr_reg;
    assign head        = mem[rd_ptr_reg];
    assign count5      = 5'(count_reg);
    assign irq         = irq_en_reg & ~empty;
    assign unused_wdata = ^wdata[31:4];

    // Storage array, no reset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_idx] <= {perr, rx_sr[7:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            count_reg       <= '0;
            rdy_q_reg       <= 1'b0;
            rdy_q2_reg      <= 1'b0;
            overrun_reg     <= 1'b0;
            perr_sticky_reg <= 1'b0;
            irq_en_reg      <= 1'b0;
        end else begin
            rdy_q_reg  <= rx_ready;
            rdy_q2_reg <= rdy_q_reg;

            if (flush) begin
                wr_ptr_reg <= push_ok ? PTR_W'(1) : '0;
                rd_ptr_reg <= '0;
                count_reg  <= push_ok ? (PTR_W+1)'(1) : '0;
            end else begin
                if (push_ok) begin
                    wr_ptr_reg <= wr_ptr_reg + 1'b1;
                end
                if (pop_ok) begin
                    rd_ptr_reg <= rd_ptr_reg + 1'b1;
                end
                unique case ({push_ok, pop_ok})
                    2'b10:   count_reg <= count_reg + 1'b1;
                    2'b01:   count_reg <= count_reg - 1'b1;
                    default: count_reg <= count_reg;
                endcase
            end

            // Set events take priority over software clears.
            if (push_strobe & full & ~flush) begin
                overrun_reg <= 1'b1;
            end else if (ctrl_wr & wdata[1]) begin
                overrun_reg <= 1'b0;
            end

            if (push_ok & perr) begin
                perr_sticky_reg <= 1'b1;
            end else if (ctrl_wr & wdata[2]) begin
                perr_sticky_reg <= 1'b0;
            end

            if (ctrl_wr) begin
                irq_en_reg <= wdata[0];
            end
        end
    end

    always_comb begin
        rdata = '0;
        unique case (addr)
            4'h0: rdata = empty ? 32'd0 : {23'd0, head};
            4'h4: rdata = {19'd0, count5, 3'd0, irq_en_reg, perr_sticky_reg,
                           overrun_reg, full, empty};
            4'h8: rdata = {31'd0, irq_en_reg};
            default: rdata = '0;
        endcase
    end

endmodule
